// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// window of GATE_CYCLES clocks and publishes the count at each window end.
//
// state | meaning
// IDLE  | disabled; freq/overflow/gate held, no freq_valid
// ARM   | two cycles that flush the synchronizer; edges ignored
// GATE  | counting edges inside a GATE_CYCLES window, back-to-back windows

module freq_meter #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             gate
);

    localparam int unsigned         WIN_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               arm_cnt_q, arm_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic               sat_q, sat_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   freq_q, freq_d;
    logic               freq_valid_q, freq_valid_d;
    logic               overflow_q, overflow_d;
    logic               gate_q, gate_d;

    logic               edge_det;
    logic [CNT_W-1:0]   cnt_nx;
    logic               sat_nx;

    assign edge_det = sync2_q & ~prev_q;

    // Saturating count including the edge of the current cycle; used both for
    // normal accumulation and for the final-cycle publish.
    always_comb begin
        cnt_nx = edge_cnt_q;
        sat_nx = sat_q;
        if (edge_det && (edge_cnt_q != CNT_MAX)) begin
            cnt_nx = edge_cnt_q + 1'b1;
        end
        if (cnt_nx == CNT_MAX) begin
            sat_nx = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        win_cnt_d    = win_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        sat_d        = sat_q;
        sync1_d      = sig_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        freq_d       = freq_q;
        freq_valid_d = 1'b0;
        overflow_d   = overflow_q;
        gate_d       = gate_q;

        case (state_q)
            ST_IDLE: begin
                win_cnt_d  = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (en) begin
                    state_d   = ST_ARM;
                    arm_cnt_d = 1'b1;
                end
            end

            ST_ARM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (arm_cnt_q == 1'b0) begin
                    state_d    = ST_GATE;
                    win_cnt_d  = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    arm_cnt_d = arm_cnt_q - 1'b1;
                end
            end

            ST_GATE: begin
                if (!en) begin
                    state_d    = ST_IDLE;
                    win_cnt_d  = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else if (win_cnt_q == WIN_LAST) begin
                    freq_d       = cnt_nx;
                    freq_valid_d = 1'b1;
                    overflow_d   = sat_nx;
                    gate_d       = ~gate_q;
                    win_cnt_d    = '0;
                    edge_cnt_d   = '0;
                    sat_d        = 1'b0;
                end else begin
                    win_cnt_d  = win_cnt_q + 1'b1;
                    edge_cnt_d = cnt_nx;
                    sat_d      = sat_nx;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            arm_cnt_q    <= 1'b0;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            gate_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            win_cnt_q    <= win_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            freq_q       <= freq_d;
            freq_valid_q <= freq_valid_d;
            overflow_q   <= overflow_d;
            gate_q       <= gate_d;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;
    assign gate       = gate_q;

endmodule
